// File: rtl/doodle_pkg.sv
// rtl/doodle_pkg.sv - shared types, constants and hit compare for the doodle physics path
package doodle_pkg;

    localparam int COORD_W      = 32;
    localparam int DOODLE_WIDTH = 32;
    localparam int BLOCK_WIDTH  = 40;
    localparam int BLOCK_HEIGHT = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DONE
    } collider_state_t;

    // Sums are widened by one bit so a platform near the top of the coordinate
    // range never wraps and produces a false hit or miss.
    function automatic logic rect_hit(
        input logic [COORD_W-1:0] dx,
        input logic [COORD_W-1:0] dy,
        input logic [COORD_W-1:0] px,
        input logic [COORD_W-1:0] py
    );
        logic [COORD_W:0] dx_e;
        logic [COORD_W:0] dy_e;
        logic [COORD_W:0] px_e;
        logic [COORD_W:0] py_e;
        dx_e = {1'b0, dx};
        dy_e = {1'b0, dy};
        px_e = {1'b0, px};
        py_e = {1'b0, py};
        return (py_e <= dy_e)
            && (dy_e < py_e + (COORD_W+1)'(BLOCK_HEIGHT))
            && (dx_e < px_e + (COORD_W+1)'(BLOCK_WIDTH))
            && (dx_e + (COORD_W+1)'(DOODLE_WIDTH) > px_e);
    endfunction

endpackage

// File: rtl/platform_table.sv
// rtl/platform_table.sv - platform rectangle register file, sync write, async read
module platform_table
    import doodle_pkg::*;
#(
    parameter int NUM_PLATFORMS = 8,
    parameter int IDX_W         = $clog2(NUM_PLATFORMS)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               we,
    input  logic [IDX_W-1:0]   waddr,
    input  logic [COORD_W-1:0] wx,
    input  logic [COORD_W-1:0] wy,
    input  logic               wvalid,
    input  logic [IDX_W-1:0]   raddr,
    output logic [COORD_W-1:0] rx,
    output logic [COORD_W-1:0] ry,
    output logic               rvalid
);

    logic [COORD_W-1:0]       px_mem [NUM_PLATFORMS];
    logic [COORD_W-1:0]       py_mem [NUM_PLATFORMS];
    logic [NUM_PLATFORMS-1:0] valid_mem;

    // Coordinates are don't-care while the valid bit is clear, so only the
    // valid bits need a reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_mem <= '0;
        end else if (we) begin
            valid_mem[waddr] <= wvalid;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && we) begin
            px_mem[waddr] <= wx;
            py_mem[waddr] <= wy;
        end
    end

    assign rx     = px_mem[raddr];
    assign ry     = py_mem[raddr];
    assign rvalid = valid_mem[raddr];

endmodule

// File: rtl/platform_collider.sv
// rtl/platform_collider.sv - sequential doodle-vs-platform landing scan per physics tick
module platform_collider
    import doodle_pkg::*;
#(
    parameter int NUM_PLATFORMS = 8,
    parameter int IDX_W         = $clog2(NUM_PLATFORMS)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               physics_tick,
    input  logic [COORD_W-1:0] doodle_x,
    input  logic [COORD_W-1:0] doodle_y,
    input  logic               falling,
    input  logic               plat_we,
    input  logic [IDX_W-1:0]   plat_waddr,
    input  logic [COORD_W-1:0] plat_wx,
    input  logic [COORD_W-1:0] plat_wy,
    input  logic               plat_wvalid,
    output logic               has_collide,
    output logic [IDX_W-1:0]   collide_idx,
    output logic [COORD_W-1:0] collide_y,
    output logic               scan_busy,
    output logic               scan_done,
    output logic               tick_overrun
);

    collider_state_t    state;
    logic [IDX_W-1:0]   idx;
    logic [COORD_W-1:0] snap_x;
    logic [COORD_W-1:0] snap_y;
    logic               snap_falling;
    logic [COORD_W-1:0] ent_x;
    logic [COORD_W-1:0] ent_y;
    logic               ent_valid;
    logic               entry_hit;

    platform_table #(
        .NUM_PLATFORMS (NUM_PLATFORMS),
        .IDX_W         (IDX_W)
    ) u_table (
        .clk    (clk),
        .reset  (reset),
        .we     (plat_we),
        .waddr  (plat_waddr),
        .wx     (plat_wx),
        .wy     (plat_wy),
        .wvalid (plat_wvalid),
        .raddr  (idx),
        .rx     (ent_x),
        .ry     (ent_y),
        .rvalid (ent_valid)
    );

    assign entry_hit = ent_valid && snap_falling && rect_hit(snap_x, snap_y, ent_x, ent_y);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            idx          <= '0;
            snap_x       <= '0;
            snap_y       <= '0;
            snap_falling <= 1'b0;
            has_collide  <= 1'b0;
            collide_idx  <= '0;
            collide_y    <= '0;
            scan_busy    <= 1'b0;
            scan_done    <= 1'b0;
            tick_overrun <= 1'b0;
        end else begin
            scan_done <= 1'b0;
            if (physics_tick && state != ST_IDLE) begin
                tick_overrun <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (physics_tick) begin
                        snap_x       <= doodle_x;
                        snap_y       <= doodle_y;
                        snap_falling <= falling;
                        idx          <= '0;
                        scan_busy    <= 1'b1;
                        state        <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    // First hit ends the scan, so the lowest index wins.
                    if (entry_hit) begin
                        has_collide <= 1'b1;
                        collide_idx <= idx;
                        collide_y   <= ent_y + COORD_W'(BLOCK_HEIGHT - 1);
                        scan_done   <= 1'b1;
                        state       <= ST_DONE;
                    end else if (idx == IDX_W'(NUM_PLATFORMS - 1)) begin
                        has_collide <= 1'b0;
                        collide_idx <= '0;
                        collide_y   <= '0;
                        scan_done   <= 1'b1;
                        state       <= ST_DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                ST_DONE: begin
                    scan_busy <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: begin
                    scan_busy <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_platform_collider.sv
// tb/tb_platform_collider.sv - directed scoreboard bench for platform_collider
module tb_platform_collider;

    localparam int N  = 8;
    localparam int IW = 3;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          physics_tick = 1'b0;
    logic [CW-1:0] doodle_x = '0;
    logic [CW-1:0] doodle_y = '0;
    logic          falling = 1'b0;
    logic          plat_we = 1'b0;
    logic [IW-1:0] plat_waddr = '0;
    logic [CW-1:0] plat_wx = '0;
    logic [CW-1:0] plat_wy = '0;
    logic          plat_wvalid = 1'b0;
    logic          has_collide;
    logic [IW-1:0] collide_idx;
    logic [CW-1:0] collide_y;
    logic          scan_busy;
    logic          scan_done;
    logic          tick_overrun;

    typedef struct {
        logic          has;
        logic [IW-1:0] idx;
        logic [CW-1:0] y;
        int            lat;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   t0 = 0;

    platform_collider #(.NUM_PLATFORMS(N)) dut (
        .clk          (clk),
        .reset        (reset),
        .physics_tick (physics_tick),
        .doodle_x     (doodle_x),
        .doodle_y     (doodle_y),
        .falling      (falling),
        .plat_we      (plat_we),
        .plat_waddr   (plat_waddr),
        .plat_wx      (plat_wx),
        .plat_wy      (plat_wy),
        .plat_wvalid  (plat_wvalid),
        .has_collide  (has_collide),
        .collide_idx  (collide_idx),
        .collide_y    (collide_y),
        .scan_busy    (scan_busy),
        .scan_done    (scan_done),
        .tick_overrun (tick_overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, ".has"}, 64'(has_collide), 64'd0);
        check({tag, ".idx"}, 64'(collide_idx), 64'd0);
        check({tag, ".y"}, 64'(collide_y), 64'd0);
        check({tag, ".busy"}, 64'(scan_busy), 64'd0);
        check({tag, ".done"}, 64'(scan_done), 64'd0);
        check({tag, ".ovr"}, 64'(tick_overrun), 64'd0);
    endtask

    task automatic write_plat(input int a, input int x, input int y, input logic v);
        plat_we = 1'b1;
        plat_waddr = IW'(a);
        plat_wx = CW'(x);
        plat_wy = CW'(y);
        plat_wvalid = v;
        step();
        plat_we = 1'b0;
    endtask

    // Drives the tick and pushes the expectation; returns just after edge E0.
    task automatic start_scan(input int dx, input int dy, input logic f,
                              input logic eh, input int ei, input int ey, input int el);
        exp_t e;
        doodle_x = CW'(dx);
        doodle_y = CW'(dy);
        falling = f;
        physics_tick = 1'b1;
        e.has = eh;
        e.idx = IW'(ei);
        e.y = CW'(ey);
        e.lat = el;
        sb.push_back(e);
        step();
        physics_tick = 1'b0;
        t0 = cyc;
        // Scrambling the live inputs proves the scan uses the snapshot.
        doodle_x = 32'hFFFF_0000;
        doodle_y = 32'h0;
        falling = 1'b0;
    endtask

    task automatic finish_scan(input string tag);
        exp_t e;
        int   budget;
        budget = 0;
        while (!scan_done && budget < 3 * N) begin
            step();
            budget++;
        end
        if (sb.size() == 0) begin
            check({tag, ".sb_empty"}, 64'd1, 64'd0);
        end else begin
            e = sb.pop_front();
            check({tag, ".done_seen"}, 64'(scan_done), 64'd1);
            check({tag, ".latency"}, 64'(cyc - t0), 64'(e.lat));
            check({tag, ".has"}, 64'(has_collide), 64'(e.has));
            check({tag, ".idx"}, 64'(collide_idx), 64'(e.idx));
            check({tag, ".y"}, 64'(collide_y), 64'(e.y));
            check({tag, ".busy_in_done"}, 64'(scan_busy), 64'd1);
            step();
            check({tag, ".done_pulse"}, 64'(scan_done), 64'd0);
            check({tag, ".busy_after"}, 64'(scan_busy), 64'd0);
            check({tag, ".has_held"}, 64'(has_collide), 64'(e.has));
        end
    endtask

    task automatic run_scan(input string tag, input int dx, input int dy, input logic f,
                            input logic eh, input int ei, input int ey, input int el);
        start_scan(dx, dy, f, eh, ei, ey, el);
        finish_scan(tag);
    endtask

    initial begin
        repeat (3) step();
        reset = 1'b0;
        check_idle_zero("reset");

        write_plat(3, 100, 50, 1'b1);
        run_scan("early_hit", 90, 52, 1'b1, 1'b1, 3, 57, 4);
        run_scan("not_falling", 90, 52, 1'b0, 1'b0, 0, 0, N);

        write_plat(5, 100, 50, 1'b1);
        write_plat(2, 95, 48, 1'b1);
        run_scan("lowest_idx", 90, 52, 1'b1, 1'b1, 2, 55, 3);

        write_plat(2, 0, 0, 1'b0);
        write_plat(3, 0, 0, 1'b0);
        run_scan("dx_right_edge", 140, 52, 1'b1, 1'b0, 0, 0, N);
        run_scan("dx_right_in", 139, 52, 1'b1, 1'b1, 5, 57, 6);
        run_scan("dx_left_edge", 68, 52, 1'b1, 1'b0, 0, 0, N);
        run_scan("dx_left_in", 69, 52, 1'b1, 1'b1, 5, 57, 6);
        run_scan("dy_top_edge", 90, 58, 1'b1, 1'b0, 0, 0, N);
        run_scan("dy_bottom", 90, 50, 1'b1, 1'b1, 5, 57, 6);
        run_scan("dy_below", 90, 49, 1'b1, 1'b0, 0, 0, N);

        start_scan(90, 52, 1'b1, 1'b1, 5, 57, 6);
        repeat (2) step();
        physics_tick = 1'b1;
        step();
        physics_tick = 1'b0;
        finish_scan("overrun");
        check("overrun.sticky", 64'(tick_overrun), 64'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_idle_zero("overrun_reset");

        write_plat(0, 100, 50, 1'b1);
        start_scan(90, 52, 1'b1, 1'b1, 0, 57, 1);
        plat_we = 1'b1;
        plat_waddr = '0;
        plat_wvalid = 1'b0;
        step();
        plat_we = 1'b0;
        finish_scan("write_during_scan");
        run_scan("after_invalidate", 90, 52, 1'b1, 1'b0, 0, 0, N);

        write_plat(6, 100, 50, 1'b1);
        start_scan(90, 52, 1'b1, 1'b1, 6, 57, 7);
        repeat (4) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        sb.delete();
        check_idle_zero("reset_mid_scan");
        run_scan("after_mid_reset", 90, 52, 1'b1, 1'b0, 0, 0, N);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
